rx_slot_scheduler: RTL

Multi-port successor to the single-port RX descriptor/trigger controller. It tracks free packet slots in every core and counts pending packets per ingress port. For each pending packet it allocates a (core, slot) pair, emits an RX DMA descriptor, and, when the DMA engine reports completion, queues a per-core trigger message. It sits between the MAC/DMA engines and the core interconnect.

---
 rtl/rx_slot_scheduler.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/rx_slot_scheduler.sv
// Multi-port RX slot scheduler: tracks free slots per core and pending packets per port,
// issues (core, slot) RX descriptors round-robin and queues per-core trigger messages on DMA completion.
module rx_slot_scheduler #(
    parameter int PORT_COUNT      = 2,
    parameter int CORE_COUNT      = 8,
    parameter int SLOT_COUNT      = 16,
    parameter int LEN_WIDTH       = 16,
    parameter int CORE_ADDR_WIDTH = 16,
    parameter int SLOT_SHIFT      = 11,
    parameter int PEND_WIDTH      = 10,
    parameter int TRIG_DEPTH      = 16,
    parameter int PORT_W          = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1,
    parameter int CORE_W          = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1,
    parameter int SLOT_W          = (SLOT_COUNT > 1) ? $clog2(SLOT_COUNT) : 1,
    parameter int ADDR_WIDTH      = CORE_W + CORE_ADDR_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [PORT_COUNT-1:0]           pkt_arrive,
    input  logic [CORE_COUNT-1:0]           core_enable,
    input  logic                            core_enable_valid,
    input  logic [LEN_WIDTH-1:0]            max_pkt_len,
    input  logic                            max_pkt_len_valid,
    input  logic [CORE_W-1:0]               slot_free_core,
    input  logic [SLOT_W-1:0]               slot_free_slot,
    input  logic                            slot_free_valid,
    output logic [ADDR_WIDTH-1:0]           rx_desc_addr,
    output logic [LEN_WIDTH-1:0]            rx_desc_len,
    output logic [PORT_W+CORE_W+SLOT_W-1:0] rx_desc_tag,
    output logic                            rx_desc_valid,
    input  logic                            rx_desc_ready,
    input  logic [PORT_W+CORE_W+SLOT_W-1:0] done_tag,
    input  logic [LEN_WIDTH-1:0]            done_len,
    input  logic                            done_valid,
    output logic [CORE_W-1:0]               trig_core,
    output logic [63:0]                     trig_data,
    output logic                            trig_valid,
    input  logic                            trig_ready,
    output logic [CORE_COUNT*(SLOT_W+1)-1:0] free_count,
    output logic [2:0]                      err
);

    localparam int TAG_W   = PORT_W + CORE_W + SLOT_W;
    localparam int CNT_W   = SLOT_W + 1;
    localparam int FIFO_AW = (TRIG_DEPTH > 1) ? $clog2(TRIG_DEPTH) : 1;
    localparam int ENTRY_W = CORE_W + PORT_W + SLOT_W + LEN_WIDTH;

    logic [SLOT_COUNT-1:0] bitmap [CORE_COUNT];
    logic [CNT_W-1:0]      cnt    [CORE_COUNT];
    logic [PEND_WIDTH-1:0] pend   [PORT_COUNT];
    logic [CORE_COUNT-1:0] core_en;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [PORT_W-1:0]     port_ptr, port_sel, p_idx;
    logic [CORE_W-1:0]     core_ptr, core_sel, c_idx;
    logic [SLOT_W-1:0]     slot_sel;
    logic [SLOT_COUNT-1:0] sel_bitmap;
    logic                  port_found, core_found, load;
    logic                  free_hit, free_ok, dbl_free;
    logic [PORT_COUNT-1:0] pend_sat;

    // Round-robin search starts one past the last grant and wraps.
    always_comb begin
        port_found = 1'b0;
        port_sel   = port_ptr;
        p_idx      = port_ptr;
        for (int unsigned i = 1; i <= PORT_COUNT; i++) begin
            p_idx = PORT_W'((32'(port_ptr) + i) % PORT_COUNT);
            if (!port_found && pend[p_idx] != '0) begin
                port_found = 1'b1;
                port_sel   = p_idx;
            end
        end
        core_found = 1'b0;
        core_sel   = core_ptr;
        c_idx      = core_ptr;
        for (int unsigned i = 1; i <= CORE_COUNT; i++) begin
            c_idx = CORE_W'((32'(core_ptr) + i) % CORE_COUNT);
            if (!core_found && core_en[c_idx] && cnt[c_idx] != '0) begin
                core_found = 1'b1;
                core_sel   = c_idx;
            end
        end
        sel_bitmap = bitmap[core_sel];
        slot_sel   = '0;
        for (int unsigned s = SLOT_COUNT; s > 0; s--) begin
            if (sel_bitmap[SLOT_W'(s - 1)]) slot_sel = SLOT_W'(s - 1);
        end
    end

    assign load     = (!rx_desc_valid || rx_desc_ready) && port_found && core_found;
    assign free_hit = bitmap[slot_free_core][slot_free_slot];
    assign free_ok  = slot_free_valid && !free_hit;
    assign dbl_free = slot_free_valid && free_hit;

    for (genvar p = 0; p < PORT_COUNT; p++) begin : g_port
        logic inc, dec;
        assign inc         = pkt_arrive[p];
        assign dec         = load && (port_sel == PORT_W'(p));
        assign pend_sat[p] = inc && !dec && (pend[p] == '1);
        always_ff @(posedge clk) begin
            if (rst)
                pend[p] <= '0;
            else if (inc && !dec && pend[p] != '1)
                pend[p] <= pend[p] + PEND_WIDTH'(1);
            else if (dec && !inc)
                pend[p] <= pend[p] - PEND_WIDTH'(1);
        end
    end

    // Allocation uses the pre-edge bitmap, so a same-core return in the same cycle is simply merged.
    for (genvar c = 0; c < CORE_COUNT; c++) begin : g_core
        logic alloc_here, free_here;
        assign alloc_here = load && (core_sel == CORE_W'(c));
        assign free_here  = free_ok && (slot_free_core == CORE_W'(c));
        always_ff @(posedge clk) begin
            if (rst) begin
                bitmap[c] <= '1;
                cnt[c]    <= CNT_W'(SLOT_COUNT);
            end else begin
                if (alloc_here) bitmap[c][slot_sel]       <= 1'b0;
                if (free_here)  bitmap[c][slot_free_slot] <= 1'b1;
                cnt[c] <= cnt[c] + CNT_W'(free_here) - CNT_W'(alloc_here);
            end
        end
        assign free_count[c*CNT_W +: CNT_W] = cnt[c];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_desc_valid <= 1'b0;
            rx_desc_addr  <= '0;
            rx_desc_len   <= '0;
            rx_desc_tag   <= '0;
            port_ptr      <= '0;
            core_ptr      <= '0;
            core_en       <= '1;
            len_q         <= LEN_WIDTH'(1514);
        end else begin
            if (core_enable_valid) core_en <= core_enable;
            if (max_pkt_len_valid) len_q   <= max_pkt_len;
            if (load) begin
                rx_desc_valid <= 1'b1;
                rx_desc_addr  <= {core_sel, CORE_ADDR_WIDTH'({slot_sel, {SLOT_SHIFT{1'b0}}})};
                rx_desc_len   <= len_q;
                rx_desc_tag   <= {port_sel, core_sel, slot_sel};
                port_ptr      <= port_sel;
                core_ptr      <= core_sel;
            end else if (rx_desc_ready) begin
                rx_desc_valid <= 1'b0;
            end
        end
    end

    logic [ENTRY_W-1:0] fifo_mem [TRIG_DEPTH];
    logic [FIFO_AW:0]   wr_ptr, rd_ptr;
    logic               fifo_full, push, pop;
    logic [CORE_W-1:0]  h_core;
    logic [PORT_W-1:0]  h_port;
    logic [SLOT_W-1:0]  h_slot;
    logic [LEN_WIDTH-1:0] h_len;

    assign fifo_full  = (wr_ptr - rd_ptr) == (FIFO_AW+1)'(TRIG_DEPTH);
    assign trig_valid = (wr_ptr != rd_ptr);
    assign pop        = trig_valid && trig_ready;
    assign push       = done_valid && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr[FIFO_AW-1:0]] <= {done_tag[SLOT_W +: CORE_W], done_tag[TAG_W-1 -: PORT_W],
                                              done_tag[SLOT_W-1:0], done_len};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            err    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (FIFO_AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (FIFO_AW+1)'(1);
            if (dbl_free)                          err[0] <= 1'b1;
            if (|pend_sat)                         err[1] <= 1'b1;
            if (done_valid && fifo_full && !pop)   err[2] <= 1'b1;
        end
    end

    assign {h_core, h_port, h_slot, h_len} = fifo_mem[rd_ptr[FIFO_AW-1:0]];
    assign trig_core = h_core;
    assign trig_data = {8'd0, 8'(h_port), 8'(h_slot), 8'd0, 16'(h_len), 16'd0};

endmodule
